// File: rtl/run_ctrl_pkg.sv
// Shared encodings for the run controller: FSM states, halt causes and field widths.
package run_ctrl_pkg;

    localparam int STATE_W = 2;
    localparam int CAUSE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_HALT = 2'd3
    } run_state_e;

    typedef enum logic [CAUSE_W-1:0] {
        HC_NONE    = 3'd0,
        HC_STOP    = 3'd1,
        HC_SYSCALL = 3'd2,
        HC_BREAK   = 3'd3,
        HC_LIMIT   = 3'd4,
        HC_STEP    = 3'd5
    } halt_cause_e;

    // Which condition blocked the datapath, highest priority first.
    function automatic halt_cause_e block_cause(input logic syscall, input logic bp_hit);
        if (syscall) begin
            return HC_SYSCALL;
        end else if (bp_hit) begin
            return HC_BREAK;
        end
        return HC_STOP;
    endfunction

endpackage

// File: rtl/run_controller_sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o,
    output logic             sat_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && !sat_o) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign sat_o   = &count_q;

endmodule

// File: rtl/run_controller.sv
// Execution sequencer for the single-cycle datapath: owns cpu_en and decides
// when the core runs, single-steps or halts, and why it last halted.
module run_controller
    import run_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              go_pulse,
    input  logic              step_pulse,
    input  logic              stop_req,
    input  logic              syscall_halt,
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic [ADDR_W-1:0] pc,
    input  logic [CNT_W-1:0]  cycle_limit,
    output logic              cpu_en,
    output logic [1:0]        state,
    output logic [2:0]        halt_cause,
    output logic [CNT_W-1:0]  exec_count
);

    run_state_e       state_q, state_d;
    halt_cause_e      cause_q, cause_d;
    logic             bp_skip_q, bp_skip_d;
    logic             bp_hit;
    logic             limit_hit;
    logic             budget_clr;
    logic             budget_en;
    logic             budget_sat;
    logic             exec_sat;
    logic             exec_en;
    logic [CNT_W-1:0] budget_cnt;
    halt_cause_e      block_c;

    assign bp_hit  = bp_en && (pc == bp_addr) && !bp_skip_q;
    assign cpu_en  = ((state_q == ST_RUN) || (state_q == ST_STEP))
                     && !syscall_halt && !bp_hit && !stop_req;
    assign block_c = block_cause(syscall_halt, bp_hit);

    // A saturated budget can never match a nonzero limit, which also keeps the +1 from wrapping.
    assign limit_hit = (cycle_limit != '0) && !budget_sat
                       && ((budget_cnt + CNT_W'(1)) == cycle_limit);

    assign budget_en = cpu_en && (state_q == ST_RUN);
    assign exec_en   = cpu_en && !exec_sat;

    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        bp_skip_d  = 1'b0;
        budget_clr = 1'b0;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (!stop_req && (cause_q != HC_SYSCALL) && (step_pulse || go_pulse)) begin
                    state_d    = step_pulse ? ST_STEP : ST_RUN;
                    budget_clr = !step_pulse;
                    bp_skip_d  = (cause_q == HC_BREAK);
                end
            end
            ST_RUN: begin
                bp_skip_d = bp_skip_q && !cpu_en;
                if (!cpu_en) begin
                    state_d = ST_HALT;
                    cause_d = block_c;
                end else if (limit_hit) begin
                    state_d = ST_HALT;
                    cause_d = HC_LIMIT;
                end
            end
            ST_STEP: begin
                bp_skip_d = bp_skip_q && !cpu_en;
                state_d   = ST_HALT;
                cause_d   = cpu_en ? HC_STEP : block_c;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            cause_q   <= HC_NONE;
            bp_skip_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            bp_skip_q <= bp_skip_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_exec_cnt (
        .clk_i   (clk),
        .rst_i   (RST),
        .clr_i   (1'b0),
        .en_i    (exec_en),
        .count_o (exec_count),
        .sat_o   (exec_sat)
    );

    sat_counter #(.CNT_W(CNT_W)) u_budget_cnt (
        .clk_i   (clk),
        .rst_i   (RST),
        .clr_i   (budget_clr),
        .en_i    (budget_en),
        .count_o (budget_cnt),
        .sat_o   (budget_sat)
    );

    assign state      = state_q;
    assign halt_cause = cause_q;

endmodule

// File: tb/tb_run_controller.sv
// Self-checking bench for run_controller: table vectors, directed corner sequences
// and randomized traffic, all compared against a behavioural model of the sequencer.
module tb_run_controller;

    localparam int ADDR_W = 32;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              goPulse, stepPulse, stopReq, syscallHalt, bpEn;
    logic [ADDR_W-1:0] bpAddr, pc;
    logic [CNT_W-1:0]  cycleLimit;
    logic              cpuEn;
    logic [1:0]        state;
    logic [2:0]        haltCause;
    logic [CNT_W-1:0]  execCount;

    int total = 0;
    int bad   = 0;

    // Behavioural model: state 0..3, cause 0..5, committed count and run budget.
    int mState, mCause, mExec, mBudget;
    bit mSkip;
    bit autoPc;
    bit lastDutEn;
    int enSeen;

    typedef struct {
        bit go, step, stop, sys;
        bit expEn;
        int expState;
        int expCause;
    } vec_t;

    vec_t vecs[12];

    run_controller #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .RST          (rst),
        .go_pulse     (goPulse),
        .step_pulse   (stepPulse),
        .stop_req     (stopReq),
        .syscall_halt (syscallHalt),
        .bp_en        (bpEn),
        .bp_addr      (bpAddr),
        .pc           (pc),
        .cycle_limit  (cycleLimit),
        .cpu_en       (cpuEn),
        .state        (state),
        .halt_cause   (haltCause),
        .exec_count   (execCount)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit modelHit();
        return bpEn && (pc == bpAddr) && !mSkip;
    endfunction

    function automatic bit modelEn();
        return (mState == 1 || mState == 2) && !syscallHalt && !modelHit() && !stopReq;
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic modelClock(input bit en);
        bit hit;
        int blockCause;
        hit = modelHit();
        blockCause = syscallHalt ? 2 : (hit ? 3 : 1);
        if (rst) begin
            mState = 0; mCause = 0; mExec = 0; mBudget = 0; mSkip = 0;
            return;
        end
        if (mState == 0 || mState == 3) begin
            bit leave;
            leave = !stopReq && (mCause != 2) && (stepPulse || goPulse);
            mSkip = leave && (mCause == 3);
            if (leave && stepPulse) begin
                mState = 2;
            end else if (leave) begin
                mState = 1;
                mBudget = 0;
            end
        end else if (mState == 1) begin
            if (!en) begin
                mState = 3;
                mCause = blockCause;
            end else begin
                if (cycleLimit != 0 && mBudget + 1 == int'(cycleLimit)) begin
                    mState = 3;
                    mCause = 4;
                end
                mExec   = (mExec < CMAX) ? mExec + 1 : CMAX;
                mBudget = (mBudget < CMAX) ? mBudget + 1 : CMAX;
                mSkip   = 0;
            end
        end else begin
            mState = 3;
            mCause = en ? 5 : blockCause;
            if (en) begin
                mExec = (mExec < CMAX) ? mExec + 1 : CMAX;
                mSkip = 0;
            end
        end
    endtask

    // One cycle: compare against the model, clock, then advance the datapath PC if enabled.
    task automatic applyStimulus();
        bit en;
        #1;
        en = modelEn();
        lastDutEn = cpuEn;
        checkOutput("cpu_en", int'(cpuEn), int'(en));
        checkOutput("state", int'(state), mState);
        checkOutput("halt_cause", int'(haltCause), mCause);
        checkOutput("exec_count", int'(execCount), mExec);
        if (cpuEn) enSeen++;
        @(posedge clk);
        modelClock(en);
        #1;
        if (autoPc && en) pc = pc + 4;
        goPulse   = 1'b0;
        stepPulse = 1'b0;
        @(negedge clk);
    endtask

    task automatic doReset();
        goPulse = 0; stepPulse = 0; stopReq = 0; syscallHalt = 0;
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; goPulse = 0; stepPulse = 0; stopReq = 0; syscallHalt = 0;
        bpEn = 0; bpAddr = '0; pc = '0; cycleLimit = '0;
        autoPc = 0; enSeen = 0;
        mState = 0; mCause = 0; mExec = 0; mBudget = 0; mSkip = 0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        checkOutput("rst_state", int'(state), 0);
        checkOutput("rst_cause", int'(haltCause), 0);
        checkOutput("rst_exec", int'(execCount), 0);
        checkOutput("rst_en", int'(cpuEn), 0);

        // Table vectors: step, stop-blocked request, run, stop, blocked step, syscall lockout.
        vecs[0]  = '{0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 1, 0, 0, 0, 2, 0};
        vecs[2]  = '{0, 0, 0, 0, 1, 3, 5};
        vecs[3]  = '{1, 1, 1, 0, 0, 3, 5};
        vecs[4]  = '{1, 0, 0, 0, 0, 1, 5};
        vecs[5]  = '{0, 0, 0, 0, 1, 1, 5};
        vecs[6]  = '{0, 0, 1, 0, 0, 3, 1};
        vecs[7]  = '{0, 1, 0, 0, 0, 2, 1};
        vecs[8]  = '{0, 0, 0, 1, 0, 3, 2};
        vecs[9]  = '{1, 0, 0, 0, 0, 3, 2};
        vecs[10] = '{0, 1, 0, 0, 0, 3, 2};
        vecs[11] = '{1, 1, 0, 0, 0, 3, 2};
        doReset();
        foreach (vecs[i]) begin
            goPulse = vecs[i].go; stepPulse = vecs[i].step;
            stopReq = vecs[i].stop; syscallHalt = vecs[i].sys;
            applyStimulus();
            checkOutput($sformatf("vec%0d_en", i), int'(lastDutEn), int'(vecs[i].expEn));
            checkOutput($sformatf("vec%0d_state", i), int'(state), vecs[i].expState);
            checkOutput($sformatf("vec%0d_cause", i), int'(haltCause), vecs[i].expCause);
        end
        stopReq = 0; syscallHalt = 0;
        checkOutput("vec_exec", int'(execCount), 2);

        // Syscall exit on the 10th enabled cycle, then a locked-out go.
        doReset();
        goPulse = 1; applyStimulus();
        for (int i = 0; i < 9; i++) applyStimulus();
        syscallHalt = 1; applyStimulus();
        checkOutput("sys_en", int'(lastDutEn), 0);
        syscallHalt = 0;
        checkOutput("sys_state", int'(state), 3);
        checkOutput("sys_cause", int'(haltCause), 2);
        checkOutput("sys_exec", int'(execCount), 9);
        goPulse = 1; applyStimulus();
        checkOutput("sys_go_ignored", int'(state), 3);

        // Three single steps spaced four cycles apart.
        doReset();
        enSeen = 0;
        for (int k = 0; k < 3; k++) begin
            stepPulse = 1; applyStimulus();
            applyStimulus();
            checkOutput($sformatf("step%0d_cause", k), int'(haltCause), 5);
            applyStimulus();
            applyStimulus();
        end
        checkOutput("step_en_cycles", enSeen, 3);
        checkOutput("step_exec", int'(execCount), 3);

        // Breakpoint at 0x10 with the PC advancing by 4 per committed instruction.
        doReset();
        bpEn = 1; bpAddr = 32'h10; pc = '0; autoPc = 1;
        goPulse = 1; applyStimulus();
        for (int i = 0; i < 30 && state != 2'd3; i++) applyStimulus();
        checkOutput("bp_state", int'(state), 3);
        checkOutput("bp_pc", int'(pc), 32'h10);
        checkOutput("bp_cause", int'(haltCause), 3);
        checkOutput("bp_exec", int'(execCount), 4);
        goPulse = 1; applyStimulus();
        applyStimulus();
        applyStimulus();
        applyStimulus();
        checkOutput("bp_resume_exec", int'(execCount), 7);
        checkOutput("bp_resume_pc", int'(pc), 32'h1c);
        checkOutput("bp_resume_state", int'(state), 1);
        autoPc = 0; bpEn = 0;

        // Cycle budget of five, run twice.
        doReset();
        cycleLimit = 5;
        for (int r = 1; r <= 2; r++) begin
            goPulse = 1; applyStimulus();
            enSeen = 0;
            for (int i = 0; i < 20 && state != 2'd3; i++) applyStimulus();
            checkOutput($sformatf("limit%0d_en_cycles", r), enSeen, 5);
            checkOutput($sformatf("limit%0d_cause", r), int'(haltCause), 4);
            checkOutput($sformatf("limit%0d_exec", r), int'(execCount), 5 * r);
        end
        cycleLimit = 0;

        // Stop button mid-run, request ignored while held, accepted after release.
        doReset();
        goPulse = 1; applyStimulus();
        for (int i = 0; i < 3; i++) applyStimulus();
        stopReq = 1; applyStimulus();
        checkOutput("stop_en", int'(lastDutEn), 0);
        checkOutput("stop_state", int'(state), 3);
        checkOutput("stop_cause", int'(haltCause), 1);
        goPulse = 1; applyStimulus();
        checkOutput("stop_go_ignored", int'(state), 3);
        stopReq = 0; goPulse = 1; applyStimulus();
        checkOutput("stop_release_go", int'(state), 1);

        // Reset in the middle of a run, then simultaneous go and step.
        doReset();
        goPulse = 1; applyStimulus();
        for (int i = 0; i < 7; i++) applyStimulus();
        checkOutput("midrst_exec_before", int'(execCount), 7);
        rst = 1; applyStimulus(); rst = 0;
        checkOutput("midrst_state", int'(state), 0);
        checkOutput("midrst_exec", int'(execCount), 0);
        checkOutput("midrst_cause", int'(haltCause), 0);
        checkOutput("midrst_en", int'(cpuEn), 0);
        goPulse = 1; stepPulse = 1; applyStimulus();
        checkOutput("go_step_prio", int'(state), 2);

        // Randomized traffic against the model, including saturation and breakpoint re-arming.
        doReset();
        bpAddr = 32'h10; pc = '0; autoPc = 1;
        for (int i = 0; i < 1500; i++) begin
            rst         = ($urandom % 100) == 0;
            goPulse     = ($urandom % 6) == 0;
            stepPulse   = ($urandom % 9) == 0;
            stopReq     = ($urandom % 10) == 0;
            syscallHalt = ($urandom % 40) == 0;
            bpEn        = ($urandom % 3) != 0;
            if (($urandom % 50) == 0) cycleLimit = CNT_W'($urandom % 7);
            if (pc >= 64) pc = '0;
            if (($urandom % 30) == 0) pc = ADDR_W'(($urandom % 16) * 4);
            applyStimulus();
        end
        rst = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/run_controller.md
Name: run_controller

Overview:
- Execution sequencer for the single-cycle MIPS datapath.
- Owns the datapath's advance enable (`cpu_en`), which replaces the raw halt/stop gating of PC, register-file and data-memory writes.
- Supports free run, single step, PC breakpoint, cycle budget, stop button and syscall-exit halt.
- Reports state, halt cause and executed-instruction count to the segment-display mux.

Parameters:
- ADDR_W, 32, PC / breakpoint address width
- CNT_W, 16, width of cycle budget and executed-instruction counters

Ports:
- clk  in  1  system clock (the divided CPU clock in the datapath)
- RST  in  1  reset, synchronous, active-high
- go_pulse  in  1  one-cycle run request (debounced button)
- step_pulse  in  1  one-cycle single-step request
- stop_req  in  1  stop button level
- syscall_halt  in  1  syscall exit condition (syscall & equal), combinational from datapath
- bp_en  in  1  breakpoint enable
- bp_addr  in  ADDR_W  breakpoint PC
- pc  in  ADDR_W  current PC (pc_dout)
- cycle_limit  in  CNT_W  run budget in instructions; 0 = unlimited
- cpu_en  out  1  datapath advance/write enable, combinational
- state  out  2  current FSM state
- halt_cause  out  3  cause of last halt
- exec_count  out  CNT_W  instructions executed since reset, saturating

Behaviour:
- Reset: state=IDLE; halt_cause=NONE; exec_count=0; budget counter=0; bp_skip=0; cpu_en=0.
- States: IDLE=0, RUN=1, STEP=2, HALT=3.
- Halt causes: NONE=0, STOP=1, SYSCALL=2, BREAK=3, LIMIT=4, STEP=5.
- Combinational breakpoint hit: bp_hit = bp_en & (pc==bp_addr) & ~bp_skip.
- Combinational enable: cpu_en = (state==RUN | state==STEP) & ~syscall_halt & ~bp_hit & ~stop_req. A halting instruction is therefore never committed.
- Enabled cycle: exec_count increments and saturates at all-ones. In RUN only, the budget counter also increments.
- IDLE/HALT transitions:
  - step_pulse -> STEP (step wins if go_pulse is also high).
  - Otherwise go_pulse -> RUN, and the budget counter clears.
  - If halt_cause==SYSCALL, both requests are ignored; only RST leaves this halt.
  - A request is ignored while stop_req=1.
  - Leaving HALT with halt_cause==BREAK sets bp_skip=1, so the breakpoint PC executes once.
- RUN: evaluate causes in this priority (first match wins), all moving to HALT:
  1. syscall_halt -> cause SYSCALL
  2. bp_hit -> cause BREAK
  3. stop_req -> cause STOP
  4. cycle_limit!=0 and budget counter+1 == cycle_limit on an enabled cycle -> cause LIMIT. That final instruction commits.
  - Otherwise stay in RUN.
- STEP: lasts exactly one cycle, then HALT.
  - If cpu_en=1, cause=STEP (one instruction committed).
  - Otherwise cause = the blocking condition, same priority as RUN.
- bp_skip clears on the first enabled cycle after it was set. It is forced to 0 while not in RUN/STEP except at the departure cycle.
- halt_cause holds until the next HALT entry or RST.
- go_pulse/step_pulse while in RUN/STEP are ignored.
- RST mid-RUN: next cycle IDLE with cpu_en=0; counters clear.
- exec_count saturates at all-ones and never wraps. The budget counter is compared before its increment.

Decomposition:
- Package run_ctrl_pkg holds:
  - state encodings (ST_IDLE..ST_HALT)
  - halt-cause codes (HC_NONE..HC_STEP)
  - widths of the state and cause fields
- One natural sub-module: sat_counter (CNT_W, synchronous clear, enable, saturate flag). Instantiate it twice, for exec_count and the budget counter.

Test Plan:
- RST then go_pulse, cycle_limit=0, syscall_halt at the 10th enabled cycle -> cpu_en low that same cycle; state=HALT, cause=2, exec_count=9; later go_pulse ignored.
- From IDLE, three step_pulses spaced 4 cycles apart -> cpu_en high exactly 3 single cycles; exec_count=3; cause=5 after each step.
- bp_en=1, bp_addr=0x0000_0010, pc stepping +4 from 0 -> halt with pc=0x10 uncommitted, cause=3, exec_count=4; go_pulse -> the instruction at 0x10 commits and run continues past it.
- cycle_limit=5, go_pulse -> exactly 5 enabled cycles, then HALT with cause=4; a second go_pulse runs 5 more (exec_count=10).
- stop_req asserted in RUN -> cpu_en=0 the same cycle, cause=1; go_pulse while stop_req=1 ignored; released then go_pulse -> RUN.
- RST asserted mid-RUN with exec_count=7 -> next cycle state=IDLE, exec_count=0, cause=0, cpu_en=0; go_pulse and step_pulse in the same cycle -> STEP.
